// File: rtl/xbar_pkg.sv
// Shared types and helpers for the stream crossbar arbiter.
// Grant vectors are built at a fixed maximum width and resized by the caller.
package xbar_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    localparam int unsigned MAX_SOURCES = 32;

    function automatic logic [MAX_SOURCES-1:0] onehot(input int unsigned index,
                                                      input int unsigned count);
        logic [MAX_SOURCES-1:0] vec;
        vec = '0;
        if (index < count && index < MAX_SOURCES) begin
            vec[index[4:0]] = 1'b1;
        end
        return vec;
    endfunction

    // Wraps at count-1, not at the next power of two.
    function automatic int unsigned wrap_next(input int unsigned index,
                                              input int unsigned count);
        return (index + 32'd1 >= count) ? 32'd0 : index + 32'd1;
    endfunction

endpackage

// File: rtl/xbar_arbiter_rr.sv
// Round-robin packet arbiter for one crossbar output: locks the output to the
// chosen source until that source's last beat is handshaken.
module rr_arbiter
    import xbar_pkg::*;
#(
    parameter int unsigned S_DATA_COUNT = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [S_DATA_COUNT-1:0] req_i,
    input  logic                    hs_last_i,
    output logic [S_DATA_COUNT-1:0] grant_o,
    output logic                    busy_o
);

    localparam int unsigned PTR_W = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;

    arb_state_e              state_q, state_d;
    logic [S_DATA_COUNT-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;

    always_comb begin
        int unsigned cand;
        int unsigned pick;
        int unsigned owner;
        logic        found;

        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cand    = 0;
        pick    = 0;
        owner   = 0;
        found   = 1'b0;

        // Search starts at ptr_q so the most recently served source goes last.
        for (int unsigned k = 0; k < S_DATA_COUNT; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= S_DATA_COUNT) begin
                cand = cand - S_DATA_COUNT;
            end
            if (!found && req_i[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        for (int unsigned s = 0; s < S_DATA_COUNT; s++) begin
            if (grant_q[s]) begin
                owner = s;
            end
        end

        unique case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    state_d = ARB_BUSY;
                    grant_d = S_DATA_COUNT'(onehot(pick, S_DATA_COUNT));
                end
            end
            ARB_BUSY: begin
                if (hs_last_i) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = PTR_W'(wrap_next(owner, S_DATA_COUNT));
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == ARB_BUSY);

endmodule

// File: rtl/xbar_arbiter.sv
// Per-output packet arbitration for the stream crossbar: builds request and
// last-handshake vectors per output and returns per-source ready.
module xbar_arbiter
    import xbar_pkg::*;
#(
    parameter  int unsigned T_DATA_WIDTH = 8,
    parameter  int unsigned S_DATA_COUNT = 2,
    parameter  int unsigned M_DATA_COUNT = 3,
    localparam int unsigned T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
    input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
    input  logic [S_DATA_COUNT-1:0]                    s_last_i,
    output logic [S_DATA_COUNT-1:0]                    s_ready_o,
    input  logic [M_DATA_COUNT-1:0]                    m_ready_i,
    output logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] grant_o,
    output logic [M_DATA_COUNT-1:0]                    busy_o
);

    if (T_DATA_WIDTH == 0) begin : g_bad_width
        $error("T_DATA_WIDTH must be nonzero");
    end

    logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req;
    logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] grant;
    logic [M_DATA_COUNT-1:0]                   hs_last;

    // Out-of-range destinations match no output, so they are never granted.
    always_comb begin
        req     = '0;
        hs_last = '0;
        for (int unsigned m = 0; m < M_DATA_COUNT; m++) begin
            for (int unsigned s = 0; s < S_DATA_COUNT; s++) begin
                req[m][s] = s_valid_i[s] && (s_dest_i[s] == T_DEST_WIDTH'(m));
            end
            hs_last[m] = m_ready_i[m] && (|(grant[m] & s_valid_i & s_last_i));
        end
    end

    always_comb begin
        s_ready_o = '0;
        for (int unsigned s = 0; s < S_DATA_COUNT; s++) begin
            for (int unsigned m = 0; m < M_DATA_COUNT; m++) begin
                if ((s_dest_i[s] == T_DEST_WIDTH'(m)) && m_ready_i[m] && grant[m][s]) begin
                    s_ready_o[s] = 1'b1;
                end
            end
        end
    end

    for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_out
        rr_arbiter #(
            .S_DATA_COUNT(S_DATA_COUNT)
        ) u_rr (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .req_i    (req[m]),
            .hs_last_i(hs_last[m]),
            .grant_o  (grant[m]),
            .busy_o   (busy_o[m])
        );
    end

    assign grant_o = grant;

endmodule
